psram_qpi_responder: RTL and testbench

Cycle-accurate responder for the 4-bit QPI pseudo-SRAM link. It plays the device end of the bus that the PSRAM memory controller drives, so the controller can be checked in simulation and in loopback on the board without a real chip. It accepts the SPI-mode QPI-enable command, then QPI quad-write and quad-read transactions with burst support. Data is stored in an internal byte array, and the responder drives read data back on the shared nibble bus.

---
 rtl/psram_qpi_responder_if.sv | 28 ++
 rtl/psram_qpi_responder.sv | 186 ++++++++++++++++++
 tb/tb_psram_qpi_responder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psram_qpi_responder_if.sv
// Shared QPI pin bundle between the PSRAM controller (master) and the responder (slave).
// Each side drives the nibble bus through its own enable, so the wire resolves like the board net.
interface psram_qpi_responder_if;
    logic       i_psram_cs;
    wire  [3:0] io_psram_data;
    logic [3:0] host_dout;
    logic       host_oe;
    logic [3:0] dev_dout;
    logic       dev_oe;

    assign io_psram_data = host_oe ? host_dout : 4'bzzzz;
    assign io_psram_data = dev_oe  ? dev_dout  : 4'bzzzz;

    modport master (
        output i_psram_cs,
        output host_dout,
        output host_oe,
        input  io_psram_data,
        input  dev_oe
    );

    modport slave (
        input  i_psram_cs,
        input  io_psram_data,
        output dev_dout,
        output dev_oe
    );
endinterface

// File: rtl/psram_qpi_responder.sv
// Device-side model of a 4-bit QPI pseudo-SRAM: decodes SPI/QPI commands,
// stores bytes in an internal array and returns them on quad reads with fixed wait slots.
module psram_qpi_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 7
) (
    input  logic                 i_clkRAM,
    input  logic                 reset,
    psram_qpi_responder_if.slave psram,
    output logic                 o_qpiMode,
    output logic                 o_cmdError,
    output logic [23:0]          o_lastAddr
);
    localparam int MEM_DEPTH = 1 << ADDR_BITS;
    localparam int CNT_W     = $clog2(WAIT_CYCLES + 9);

    typedef enum logic [2:0] {
        SPI_CMD, QPI_CMD, ADDR, WDATA, RWAIT, RDATA, IGNORE
    } state_t;

    state_t               state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [19:0]          shift_reg, shift_next;
    logic                 write_reg, write_next;
    logic [ADDR_BITS-1:0] ptr_reg, ptr_next;
    logic                 nib_sel_reg, nib_sel_next;
    logic                 qpi_reg, qpi_next;
    logic                 err_reg, err_next;
    logic [23:0]          last_addr_reg, last_addr_next;

    logic [7:0]           mem [0:MEM_DEPTH-1];
    logic [7:0]           rd_data_reg;
    logic                 mem_we;

    logic [3:0]           sio;
    logic [7:0]           spi_byte;
    logic [7:0]           cmd_byte;
    logic [23:0]          addr_full;

    assign sio       = psram.io_psram_data;
    assign spi_byte  = {shift_reg[6:0], sio[0]};
    assign cmd_byte  = {shift_reg[3:0], sio};
    assign addr_full = {shift_reg, sio};

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        shift_next     = shift_reg;
        write_next     = write_reg;
        ptr_next       = ptr_reg;
        nib_sel_next   = nib_sel_reg;
        qpi_next       = qpi_reg;
        err_next       = err_reg;
        last_addr_next = last_addr_reg;
        mem_we         = 1'b0;

        if (psram.i_psram_cs) begin
            state_next   = qpi_reg ? QPI_CMD : SPI_CMD;
            cnt_next     = '0;
            nib_sel_next = 1'b0;
        end else begin
            case (state_reg)
                SPI_CMD: begin
                    // Count saturates at 8 so trailing bits after 0x35 are inert.
                    if (cnt_reg < CNT_W'(8)) begin
                        shift_next = {shift_reg[18:0], sio[0]};
                        cnt_next   = cnt_reg + CNT_W'(1);
                        if (cnt_reg == CNT_W'(7)) begin
                            if (spi_byte == 8'h35) begin
                                qpi_next = 1'b1;
                            end else begin
                                err_next   = 1'b1;
                                state_next = IGNORE;
                            end
                        end
                    end
                end
                QPI_CMD: begin
                    shift_next = {shift_reg[15:0], sio};
                    if (cnt_reg == '0) begin
                        cnt_next = CNT_W'(1);
                    end else begin
                        cnt_next = '0;
                        case (cmd_byte)
                            8'h38: begin
                                write_next = 1'b1;
                                state_next = ADDR;
                            end
                            8'hEB: begin
                                write_next = 1'b0;
                                state_next = ADDR;
                            end
                            8'hF5: begin
                                qpi_next   = 1'b0;
                                state_next = IGNORE;
                            end
                            default: begin
                                err_next   = 1'b1;
                                state_next = IGNORE;
                            end
                        endcase
                    end
                end
                ADDR: begin
                    // 20-bit shifter plus the live nibble spans exactly the 24-bit address.
                    shift_next = {shift_reg[15:0], sio};
                    if (cnt_reg == CNT_W'(5)) begin
                        cnt_next       = '0;
                        last_addr_next = addr_full;
                        ptr_next       = addr_full[ADDR_BITS-1:0];
                        nib_sel_next   = 1'b0;
                        if (write_reg)
                            state_next = WDATA;
                        else if (WAIT_CYCLES == 0)
                            state_next = RDATA;
                        else
                            state_next = RWAIT;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                WDATA: begin
                    shift_next   = {shift_reg[15:0], sio};
                    nib_sel_next = ~nib_sel_reg;
                    if (nib_sel_reg) begin
                        mem_we   = 1'b1;
                        ptr_next = ptr_reg + ADDR_BITS'(1);
                    end
                end
                RWAIT: begin
                    if (cnt_reg == CNT_W'(WAIT_CYCLES - 1)) begin
                        cnt_next   = '0;
                        state_next = RDATA;
                    end else begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end
                end
                RDATA: begin
                    nib_sel_next = ~nib_sel_reg;
                    if (nib_sel_reg)
                        ptr_next = ptr_reg + ADDR_BITS'(1);
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clkRAM or negedge reset) begin
        if (!reset) begin
            state_reg     <= SPI_CMD;
            cnt_reg       <= '0;
            shift_reg     <= '0;
            write_reg     <= 1'b0;
            ptr_reg       <= '0;
            nib_sel_reg   <= 1'b0;
            qpi_reg       <= 1'b0;
            err_reg       <= 1'b0;
            last_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            shift_reg     <= shift_next;
            write_reg     <= write_next;
            ptr_reg       <= ptr_next;
            nib_sel_reg   <= nib_sel_next;
            qpi_reg       <= qpi_next;
            err_reg       <= err_next;
            last_addr_reg <= last_addr_next;
        end
    end

    // Reading at the next pointer puts each byte in rd_data_reg one edge before its first slot.
    always_ff @(posedge i_clkRAM) begin
        if (mem_we)
            mem[ptr_reg] <= cmd_byte;
        rd_data_reg <= mem[ptr_next];
    end

    assign psram.dev_oe   = (state_reg == RDATA) && !psram.i_psram_cs;
    assign psram.dev_dout = nib_sel_reg ? rd_data_reg[3:0] : rd_data_reg[7:4];

    assign o_qpiMode  = qpi_reg;
    assign o_cmdError = err_reg;
    assign o_lastAddr = last_addr_reg;
endmodule

// File: tb/tb_psram_qpi_responder.sv
// Directed bench for psram_qpi_responder: plays the controller side of the QPI link
// and checks mode/error flags, latched address and read-back nibbles slot by slot.
module tb_psram_qpi_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        qpi_mode;
    logic        cmd_error;
    logic [23:0] last_addr;
    int          n_checks = 0;
    int          n_fail   = 0;

    psram_qpi_responder_if bus();

    psram_qpi_responder #(
        .ADDR_BITS  (10),
        .WAIT_CYCLES(7)
    ) dut (
        .i_clkRAM  (clk),
        .reset     (reset),
        .psram     (bus),
        .o_qpiMode (qpi_mode),
        .o_cmdError(cmd_error),
        .o_lastAddr(last_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [3:0] nib);
        @(negedge clk);
        bus.i_psram_cs = 1'b0;
        bus.host_oe    = 1'b1;
        bus.host_dout  = nib;
    endtask

    task automatic deselect(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.i_psram_cs = 1'b1;
            bus.host_oe    = 1'b0;
        end
    endtask

    task automatic slot(output logic oe, output logic [3:0] d);
        @(negedge clk);
        bus.i_psram_cs = 1'b0;
        bus.host_oe    = 1'b0;
        #4;
        oe = bus.dev_oe;
        d  = bus.io_psram_data;
    endtask

    task automatic qpi_send(input logic [7:0] b);
        xfer(b[7:4]);
        xfer(b[3:0]);
    endtask

    task automatic qpi_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--)
            xfer(a[i*4 +: 4]);
    endtask

    task automatic spi_enable(input string tag);
        logic [7:0] b;
        b = 8'h35;
        for (int i = 7; i >= 1; i--)
            xfer({3'b000, b[i]});
        @(posedge clk); #1;
        check({tag, " qpi_after_7"}, {31'd0, qpi_mode}, 32'd0);
        xfer({3'b000, b[0]});
        @(posedge clk); #1;
        check({tag, " qpi_after_8"}, {31'd0, qpi_mode}, 32'd1);
        deselect(2);
        $display("TXN spi 0x35 qpi=%0d", qpi_mode);
    endtask

    task automatic qpi_write(input logic [23:0] a, input int n, input logic [23:0] bytes);
        qpi_send(8'h38);
        qpi_addr(a);
        for (int k = 0; k < n; k++)
            qpi_send(bytes[23 - 8*k -: 8]);
        deselect(1);
        $display("TXN write addr=0x%06h n=%0d data=0x%06h", a, n, bytes);
    endtask

    task automatic qpi_read(input string tag, input logic [23:0] a, input int n, input logic [23:0] exp);
        logic       oe;
        logic       hi_oe;
        logic [3:0] d;
        logic [3:0] hi;
        int         busy;
        qpi_send(8'hEB);
        qpi_addr(a);
        @(posedge clk); #1;
        check({tag, " last_addr"}, {8'd0, last_addr}, {8'd0, a});
        busy = 0;
        for (int i = 0; i < 7; i++) begin
            slot(oe, d);
            if (oe) busy++;
        end
        check({tag, " wait_hiz"}, busy, 0);
        for (int k = 0; k < n; k++) begin
            slot(hi_oe, hi);
            slot(oe, d);
            check({tag, " data_oe"}, {30'd0, hi_oe, oe}, 32'd3);
            check({tag, " data"}, {24'd0, hi, d}, {24'd0, exp[23 - 8*k -: 8]});
            $display("TXN read addr=0x%06h byte%0d=0x%h%h", a, k, hi, d);
        end
        deselect(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       oe;
        logic [3:0] d;
        int         busy;

        reset          = 1'b0;
        bus.i_psram_cs = 1'b1;
        bus.host_oe    = 1'b0;
        bus.host_dout  = 4'h0;
        repeat (3) @(negedge clk);
        #1;
        check("reset qpi", {31'd0, qpi_mode}, 32'd0);
        check("reset err", {31'd0, cmd_error}, 32'd0);
        check("reset last_addr", {8'd0, last_addr}, 32'd0);
        check("reset oe", {31'd0, bus.dev_oe}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        deselect(2);

        // QPI-form read before QPI is enabled: SPI decode sees 0x45
        qpi_send(8'hEB);
        qpi_addr(24'h000123);
        @(posedge clk); #1;
        check("spi_bad err", {31'd0, cmd_error}, 32'd1);
        check("spi_bad qpi", {31'd0, qpi_mode}, 32'd0);
        busy = 0;
        for (int i = 0; i < 4; i++) begin
            slot(oe, d);
            if (oe) busy++;
        end
        check("spi_bad hiz", busy, 0);
        deselect(2);
        $display("TXN qpi-form 0xEB in spi mode err=%0d", cmd_error);

        @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset clears err", {31'd0, cmd_error}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        deselect(1);

        spi_enable("enable1");

        qpi_write(24'h000123, 1, 24'hA50000);
        check("write last_addr", {8'd0, last_addr}, 32'h000123);
        qpi_read("rd123", 24'h000123, 1, 24'hA50000);

        qpi_write(24'h0003FF, 3, 24'h112233);
        qpi_read("rd3ff", 24'hABC3FF, 1, 24'h110000);
        qpi_read("rd000", 24'h000000, 1, 24'h220000);
        qpi_read("rd001", 24'h000001, 1, 24'h330000);
        qpi_read("burst", 24'h0003FF, 3, 24'h112233);

        // Write aborted after the 3rd address nibble
        qpi_send(8'h38);
        xfer(4'h0);
        xfer(4'h0);
        xfer(4'h0);
        deselect(1);
        $display("TXN aborted write");
        check("abort err", {31'd0, cmd_error}, 32'd0);
        qpi_read("abort", 24'h000123, 1, 24'hA50000);

        // Trailing high nibble is dropped
        qpi_write(24'h000200, 2, 24'h5A6B00);
        qpi_send(8'h38);
        qpi_addr(24'h000200);
        qpi_send(8'hC3);
        xfer(4'h9);
        deselect(1);
        $display("TXN partial write addr=0x000200");
        qpi_read("partial", 24'h000200, 2, 24'hC36B00);

        // CS rises in the low-nibble slot: bus releases without waiting for an edge
        qpi_send(8'hEB);
        qpi_addr(24'h000123);
        for (int i = 0; i < 7; i++) slot(oe, d);
        slot(oe, d);
        check("cut hi_nibble", {28'd0, d}, 32'hA);
        @(negedge clk);
        bus.i_psram_cs = 1'b1;
        bus.host_oe    = 1'b0;
        #1;
        check("cut release", {31'd0, bus.dev_oe}, 32'd0);
        $display("TXN read cut in low-nibble slot");
        qpi_write(24'h000050, 1, 24'h770000);
        qpi_read("after_cut", 24'h000050, 1, 24'h770000);
        check("after_cut err", {31'd0, cmd_error}, 32'd0);

        // Leave QPI mode and re-enter it
        qpi_send(8'hF5);
        @(posedge clk); #1;
        check("f5 qpi", {31'd0, qpi_mode}, 32'd0);
        check("f5 err", {31'd0, cmd_error}, 32'd0);
        deselect(2);
        $display("TXN qpi 0xF5 qpi=%0d", qpi_mode);
        spi_enable("enable2");

        // Reset asserted while the responder drives read data
        qpi_send(8'hEB);
        qpi_addr(24'h000123);
        for (int i = 0; i < 7; i++) slot(oe, d);
        slot(oe, d);
        check("rst_rd oe_before", {31'd0, oe}, 32'd1);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("rst_rd oe", {31'd0, bus.dev_oe}, 32'd0);
        check("rst_rd qpi", {31'd0, qpi_mode}, 32'd0);
        @(negedge clk);
        bus.i_psram_cs = 1'b1;
        reset          = 1'b1;
        deselect(2);
        check("rst_rd qpi_held", {31'd0, qpi_mode}, 32'd0);
        $display("TXN reset during read qpi=%0d", qpi_mode);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
